// File: rtl/trap_pkg.sv
// trap_pkg: encodings shared by the trap controller and its consumers.
// flush_control and exception_pc_ctrl import these same constants.
package trap_pkg;

    localparam logic [2:0] TRAP_NONE = 3'b000;
    localparam logic [2:0] TRAP_MEM  = 3'b001;
    localparam logic [2:0] TRAP_EX   = 3'b010;
    localparam logic [2:0] TRAP_ID   = 3'b011;

    localparam logic [3:0] CAUSE_MISALIGNED  = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
    localparam logic [3:0] CAUSE_LOAD_FAULT  = 4'd5;
    localparam logic [3:0] CAUSE_STORE_FAULT = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HANDLER = 2'd1,
        ST_LOCKED  = 2'd2
    } trap_state_t;

endpackage

// File: rtl/trap_unit_if.sv
// trap_unit_if: pipeline-side requests and trap controller responses.
// master = pipeline/CSR side, slave = trap_unit.
interface trap_unit_if #(
    parameter int XLEN = 64
);
    logic            illegal_opcode_id;
    logic [XLEN-1:0] pc_id;
    logic            misaligned_ex;
    logic [XLEN-1:0] pc_ex;
    logic            fault_mem;
    logic            fault_is_store;
    logic [XLEN-1:0] pc_mem;
    logic            exception_handled;
    logic            mtvec_we;
    logic [XLEN-1:0] mtvec_wdata;
    logic [2:0]      trap_type;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mcause;
    logic            in_handler;
    logic            double_fault;

    modport master (
        output illegal_opcode_id, pc_id,
        output misaligned_ex, pc_ex,
        output fault_mem, fault_is_store, pc_mem,
        output exception_handled,
        output mtvec_we, mtvec_wdata,
        input  trap_type, redirect_valid, redirect_pc,
        input  mepc, mcause,
        input  in_handler, double_fault
    );

    modport slave (
        input  illegal_opcode_id, pc_id,
        input  misaligned_ex, pc_ex,
        input  fault_mem, fault_is_store, pc_mem,
        input  exception_handled,
        input  mtvec_we, mtvec_wdata,
        output trap_type, redirect_valid, redirect_pc,
        output mepc, mcause,
        output in_handler, double_fault
    );
endinterface

// File: rtl/trap_prio.sv
// trap_prio: picks the oldest excepting instruction (MEM > EX > ID)
// and returns its trap encoding, cause code and PC.
module trap_prio
    import trap_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            illegal_opcode_i,
    input  logic [XLEN-1:0] pc_id_i,
    input  logic            misaligned_i,
    input  logic [XLEN-1:0] pc_ex_i,
    input  logic            fault_i,
    input  logic            fault_is_store_i,
    input  logic [XLEN-1:0] pc_mem_i,
    output logic            req_o,
    output logic [2:0]      type_o,
    output logic [3:0]      cause_o,
    output logic [XLEN-1:0] pc_o
);

    // Oldest stage wins; one winner per cycle.
    always_comb begin
        req_o   = fault_i | misaligned_i | illegal_opcode_i;
        type_o  = TRAP_NONE;
        cause_o = '0;
        pc_o    = '0;
        if (fault_i) begin
            type_o  = TRAP_MEM;
            cause_o = fault_is_store_i ? CAUSE_STORE_FAULT
                                       : CAUSE_LOAD_FAULT;
            pc_o    = pc_mem_i;
        end else if (misaligned_i) begin
            type_o  = TRAP_EX;
            cause_o = CAUSE_MISALIGNED;
            pc_o    = pc_ex_i;
        end else if (illegal_opcode_i) begin
            type_o  = TRAP_ID;
            cause_o = CAUSE_ILLEGAL;
            pc_o    = pc_id_i;
        end
    end

endmodule

// File: rtl/trap_unit.sv
// trap_unit: machine-mode trap FSM with mepc/mcause/mtvec CSRs.
// Redirect and trap_type are combinational for zero-cycle flush.
module trap_unit
    import trap_pkg::*;
#(
    parameter int              XLEN        = 64,
    parameter logic [XLEN-1:0] MTVEC_RESET = 64'h0000_0000_0000_0100
) (
    input  logic      clk,
    input  logic      rst,
    trap_unit_if.slave bus
);

    trap_state_t     state_q, state_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;

    logic            req;
    logic [2:0]      win_type;
    logic [3:0]      win_cause;
    logic [XLEN-1:0] win_pc;

    localparam logic [XLEN-1:0] ALIGN_MASK =
        ~{{(XLEN-2){1'b0}}, 2'b11};

    trap_prio #(
        .XLEN (XLEN)
    ) u_prio (
        .illegal_opcode_i (bus.illegal_opcode_id),
        .pc_id_i          (bus.pc_id),
        .misaligned_i     (bus.misaligned_ex),
        .pc_ex_i          (bus.pc_ex),
        .fault_i          (bus.fault_mem),
        .fault_is_store_i (bus.fault_is_store),
        .pc_mem_i         (bus.pc_mem),
        .req_o            (req),
        .type_o           (win_type),
        .cause_o          (win_cause),
        .pc_o             (win_pc)
    );

    // Next state, CSR capture and redirect; a trap beats a return.
    always_comb begin
        state_d            = state_q;
        mepc_d             = mepc_q;
        mcause_d           = mcause_q;
        bus.trap_type      = TRAP_NONE;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = mtvec_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    bus.trap_type      = win_type;
                    bus.redirect_valid = 1'b1;
                    bus.redirect_pc    = mtvec_q;
                    mepc_d             = win_pc;
                    mcause_d = {{(XLEN-4){1'b0}}, win_cause};
                    state_d            = ST_HANDLER;
                end else if (bus.exception_handled) begin
                    bus.redirect_valid = 1'b1;
                    bus.redirect_pc    = mepc_q;
                end
            end
            ST_HANDLER: begin
                if (req) begin
                    // Nested trap: flush everything, no redirect.
                    bus.trap_type = TRAP_MEM;
                    state_d       = ST_LOCKED;
                end else if (bus.exception_handled) begin
                    bus.redirect_valid = 1'b1;
                    bus.redirect_pc    = mepc_q;
                    state_d            = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                state_d = ST_LOCKED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // mtvec write; the old value still feeds this cycle's redirect.
    always_comb begin
        mtvec_d = mtvec_q;
        if (bus.mtvec_we) begin
            mtvec_d = bus.mtvec_wdata & ALIGN_MASK;
        end
    end

    // State and CSR registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mepc_q   <= '0;
            mcause_q <= '0;
            mtvec_q  <= MTVEC_RESET;
        end else begin
            state_q  <= state_d;
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
            mtvec_q  <= mtvec_d;
        end
    end

    assign bus.mepc         = mepc_q;
    assign bus.mcause       = mcause_q;
    assign bus.in_handler   = (state_q == ST_HANDLER);
    assign bus.double_fault = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_trap_unit.sv
// tb_trap_unit: directed test plan plus random traffic checked
// against a behavioural model of the trap rules.
module tb_trap_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    trap_unit_if #(.XLEN(64)) bus ();

    trap_unit #(
        .XLEN        (64),
        .MTVEC_RESET (64'h100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // behavioural model
    bit          m_hand;
    bit          m_lock;
    logic [63:0] m_mepc;
    logic [63:0] m_mcause;
    logic [63:0] m_mtvec;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hand   = 0;
        m_lock   = 0;
        m_mepc   = 0;
        m_mcause = 0;
        m_mtvec  = 64'h100;
    endtask

    task automatic drive(bit il, bit mx, bit fm, bit st, bit eh,
                         bit we, logic [63:0] wd);
        bus.illegal_opcode_id = il;
        bus.misaligned_ex     = mx;
        bus.fault_mem         = fm;
        bus.fault_is_store    = st;
        bus.exception_handled = eh;
        bus.mtvec_we          = we;
        bus.mtvec_wdata       = wd;
    endtask

    // Check the combinational outputs against the model.
    task automatic comb_phase();
        bit          any;
        logic [2:0]  e_type;
        bit          e_rv;
        logic [63:0] e_pc;
        #1;
        any    = bus.fault_mem | bus.misaligned_ex | bus.illegal_opcode_id;
        e_type = 3'd0;
        e_rv   = 0;
        e_pc   = 64'h0;
        if (!m_lock && any) begin
            if (m_hand) begin
                e_type = 3'd1;
            end else begin
                e_type = bus.fault_mem ? 3'd1 : bus.misaligned_ex ? 3'd2 : 3'd3;
                e_rv   = 1;
                e_pc   = m_mtvec;
            end
        end else if (!m_lock && bus.exception_handled) begin
            e_rv = 1;
            e_pc = m_mepc;
        end
        chk("trap_type", 64'(bus.trap_type), 64'(e_type));
        chk("redirect_valid", 64'(bus.redirect_valid), 64'(e_rv));
        if (e_rv) chk("redirect_pc", bus.redirect_pc, e_pc);
    endtask

    // Clock edge: advance the model and check registered state.
    task automatic edge_phase();
        bit any;
        @(posedge clk);
        any = bus.fault_mem | bus.misaligned_ex | bus.illegal_opcode_id;
        if (!m_lock && any) begin
            if (m_hand) begin
                m_hand = 0;
                m_lock = 1;
            end else begin
                m_hand = 1;
                if (bus.fault_mem) begin
                    m_mepc   = bus.pc_mem;
                    m_mcause = bus.fault_is_store ? 7 : 5;
                end else if (bus.misaligned_ex) begin
                    m_mepc   = bus.pc_ex;
                    m_mcause = 0;
                end else begin
                    m_mepc   = bus.pc_id;
                    m_mcause = 2;
                end
            end
        end else if (!m_lock && bus.exception_handled) begin
            m_hand = 0;
        end
        if (bus.mtvec_we) m_mtvec = {bus.mtvec_wdata[63:2], 2'b00};
        #1;
        chk("mepc", bus.mepc, m_mepc);
        chk("mcause", bus.mcause, m_mcause);
        chk("in_handler", 64'(bus.in_handler), 64'(m_hand));
        chk("double_fault", 64'(bus.double_fault), 64'(m_lock));
        @(negedge clk);
    endtask

    task automatic reset_mid_cycle();
        drive(0, 0, 0, 0, 0, 0, 64'h0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_in_handler", 64'(bus.in_handler), 64'h0);
        chk("rst_double_fault", 64'(bus.double_fault), 64'h0);
        chk("rst_mepc", bus.mepc, 64'h0);
        chk("rst_mcause", bus.mcause, 64'h0);
        chk("rst_trap_type", 64'(bus.trap_type), 64'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        bus.pc_id  = 64'h40;
        bus.pc_ex  = 64'h60;
        bus.pc_mem = 64'h80;
        drive(0, 0, 0, 0, 0, 0, 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        comb_phase();
        edge_phase();

        // 1: illegal opcode in ID
        drive(1, 0, 0, 0, 0, 0, 64'h0);
        comb_phase();
        chk("t1_type", 64'(bus.trap_type), 64'h3);
        chk("t1_rpc", bus.redirect_pc, 64'h100);
        edge_phase();
        chk("t1_mepc", bus.mepc, 64'h40);
        chk("t1_mcause", bus.mcause, 64'h2);

        // 3: return from handler
        drive(0, 0, 0, 0, 1, 0, 64'h0);
        comb_phase();
        chk("t3_rpc", bus.redirect_pc, 64'h40);
        edge_phase();
        chk("t3_in_handler", 64'(bus.in_handler), 64'h0);

        // 2: all three stages at once
        drive(1, 1, 1, 1, 0, 0, 64'h0);
        comb_phase();
        chk("t2_type", 64'(bus.trap_type), 64'h1);
        edge_phase();
        chk("t2_mepc", bus.mepc, 64'h80);
        chk("t2_mcause", bus.mcause, 64'h7);

        // 4: nested trap locks the unit
        drive(0, 1, 0, 0, 1, 0, 64'h0);
        comb_phase();
        chk("t4_type", 64'(bus.trap_type), 64'h1);
        edge_phase();
        chk("t4_mepc", bus.mepc, 64'h80);
        chk("t4_double", 64'(bus.double_fault), 64'h1);
        drive(1, 1, 1, 0, 1, 0, 64'h0);
        comb_phase();
        chk("t4_locked_type", 64'(bus.trap_type), 64'h0);
        edge_phase();

        // 6: async reset while locked
        reset_mid_cycle();

        // 5: mtvec write coincident with trap
        drive(0, 1, 0, 0, 1, 1, 64'h203);
        comb_phase();
        chk("t5_rpc_old", bus.redirect_pc, 64'h100);
        edge_phase();
        chk("t6_in_handler", 64'(bus.in_handler), 64'h1);
        drive(0, 0, 0, 0, 1, 0, 64'h0);
        comb_phase();
        edge_phase();
        drive(1, 0, 0, 0, 0, 0, 64'h0);
        comb_phase();
        chk("t5_rpc_new", bus.redirect_pc, 64'h200);
        edge_phase();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            bus.pc_id  = {$urandom, $urandom};
            bus.pc_ex  = {$urandom, $urandom};
            bus.pc_mem = {$urandom, $urandom};
            drive($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 5) == 0, 1'($urandom),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
                  {$urandom, $urandom});
            comb_phase();
            edge_phase();
            if (m_lock && $urandom_range(0, 3) == 0) reset_mid_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/trap_unit.md
# trap_unit

Machine-mode trap controller for the RV64 pipeline. Collects exception requests from ID (illegal opcode), EX (misaligned target) and MEM (access fault), selects the oldest, and drives `trap_type` into `flush_control`. It holds `mepc`, `mcause` and `mtvec`, and supplies the PC redirect target for both trap entry and `mret` return.

## Interface
- `MTVEC_RESET`, default 64'h0000_0000_0000_0100: handler base address after reset.
- `XLEN`, default 64: PC and CSR width.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `illegal_opcode_id` in 1: ID-stage illegal opcode flag from `control_unit`.
- `pc_id` in XLEN: PC of the instruction in ID.
- `misaligned_ex` in 1: EX-stage misaligned jump/branch target.
- `pc_ex` in XLEN: PC of the instruction in EX.
- `fault_mem` in 1: MEM-stage access fault.
- `fault_is_store` in 1: qualifies `fault_mem`; 1 means store, 0 means load.
- `pc_mem` in XLEN: PC of the instruction in MEM.
- `exception_handled` in 1: `mret` accepted, from `flush_control`.
- `mtvec_we` in 1: write strobe for `mtvec`.
- `mtvec_wdata` in XLEN: new `mtvec` value; bits [1:0] are forced to 0.
- `trap_type` out 3: 000 none, 011 ID trap, 010 EX trap, 001 MEM trap.
- `redirect_valid` out 1: the PC must load `redirect_pc` this cycle.
- `redirect_pc` out XLEN: `mtvec` on trap entry, `mepc` on return.
- `mepc` out XLEN: CSR.
- `mcause` out XLEN: CSR.
- `in_handler` out 1: state is HANDLER.
- `double_fault` out 1: state is LOCKED.

## Operation
**States:**
- IDLE: normal execution.
- HANDLER: inside the trap handler.
- LOCKED: terminal double-fault state.

**Requests and priority:**
- A request is valid in IDLE and in HANDLER. In LOCKED all request inputs are ignored.
- Priority: MEM > EX > ID. The oldest instruction wins, and only one trap is taken per cycle.

**Trap taken from IDLE:**
- `trap_type` is driven per the stage encoding above.
- `redirect_valid`=1 and `redirect_pc`=`mtvec`.
- On the clock edge:
  - `mepc` <= PC of the winning stage.
  - `mcause` <= the winning code: illegal instruction = 2, instruction misaligned = 0, load fault = 5, store fault = 7.
  - state <= HANDLER.

**Trap raised while in HANDLER:**
- Outputs `trap_type`=001 so that every stage is flushed.
- `redirect_valid`=0.
- `mepc` and `mcause` hold their values.
- state <= LOCKED.

**Return (`exception_handled`=1):**
- In HANDLER: `redirect_valid`=1, `redirect_pc`=`mepc`, and state <= IDLE on the edge.
- In IDLE: redirect to `mepc` still happens, with no state change.
- In LOCKED: ignored.

**Simultaneous events:**
- Trap and return in the same cycle: the trap wins and the return is dropped. `redirect_pc`=`mtvec`.
- `mtvec_we` in the same cycle as a trap: `redirect_pc` uses the old `mtvec`, and the new value lands on the edge.

**LOCKED:**
- `trap_type`=000, `redirect_valid`=0, `double_fault`=1.
- Only `rst` exits this state.

## Timing
- `trap_type`, `redirect_valid` and `redirect_pc` are combinational from the current-cycle inputs and state. There is zero-cycle latency into `flush_control` and the PC mux.
- CSR and state updates are visible on the cycle after the event.
- Each request is sampled every cycle, with no latching. A request held for N cycles is a new request on every cycle: in IDLE the first one takes the trap, and later ones fall under the HANDLER rule.

**Reset values (`rst` asserted, asynchronously):**
- state = IDLE
- `mepc` = 0
- `mcause` = 0
- `mtvec` = `MTVEC_RESET`
- `in_handler` = 0, `double_fault` = 0
- Combinational outputs follow from these values (`trap_type`=000 unless a request input is high).

**Reset mid-operation:** a reset asserted during HANDLER or LOCKED returns to IDLE immediately. Any pending return is lost.

## Structure
**Shared package `trap_pkg`:**
- Encodings `TRAP_NONE`, `TRAP_MEM`, `TRAP_EX`, `TRAP_ID`.
- Cause constants `CAUSE_MISALIGNED`, `CAUSE_ILLEGAL`, `CAUSE_LOAD_FAULT`, `CAUSE_STORE_FAULT`.
- State enum `trap_state_t`.
- `flush_control` and `exception_pc_ctrl` import the same encodings from this package.

**Sub-module:**
- One combinational sub-module, `trap_prio`: the request-to-(`trap_type`, cause, PC) priority encoder.
- The CSRs and the FSM stay in the top module.

## Test plan
1. Reset, then `illegal_opcode_id`=1 with `pc_id`=0x40 for 1 cycle:
   - That cycle: `trap_type`=011, `redirect_pc`=0x100.
   - Next cycle: `mepc`=0x40, `mcause`=2, `in_handler`=1.
2. `fault_mem`=1 (`fault_is_store`=1, `pc_mem`=0x80), `misaligned_ex`=1 and `illegal_opcode_id`=1 all in the same cycle:
   - `trap_type`=001.
   - Next cycle: `mepc`=0x80, `mcause`=7.
3. In HANDLER, pulse `exception_handled`:
   - `redirect_pc`=`mepc`, `redirect_valid`=1.
   - Next cycle: `in_handler`=0.
4. In HANDLER, `misaligned_ex`=1:
   - `trap_type`=001 and `mepc` unchanged.
   - Next cycle: `double_fault`=1.
   - Further requests produce `trap_type`=000.
5. Write `mtvec`=0x203 and trap in the same cycle:
   - `redirect_pc`=0x100.
   - On a later trap: `redirect_pc`=0x200.
6. Assert `rst` asynchronously mid-cycle while LOCKED:
   - Outputs return to reset values before the next clock edge.
   - A trap after reset is taken normally.
